// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store port between core datapath and data memory responder
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, size, load_unsigned,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, size, load_unsigned,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder with wait states,
// byte-lane store merge, extended sub-word loads and access error flagging
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
  input logic               clk,
  input logic               reset,
  dmem_responder_if.slave   bus
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT     = 33'(BASE_ADDR) + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  cur_size;
  logic        cur_uns;
  logic        req_err;
  logic        cur_err;
  logic        enter_resp;
  logic        mem_we;
  logic [31:0] off;
  logic [IDX_W-1:0] idx;
  logic [31:0] old_word;
  logic [31:0] merged;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;

  // In IDLE the access is described by the live inputs so a zero-wait
  // configuration can commit/read on the same edge that accepts the request.
  always_comb begin
    cur_we    = (state == IDLE) ? bus.we            : we_q;
    cur_addr  = (state == IDLE) ? bus.addr          : addr_q;
    cur_wdata = (state == IDLE) ? bus.wdata         : wdata_q;
    cur_size  = (state == IDLE) ? bus.size          : size_q;
    cur_uns   = (state == IDLE) ? bus.load_unsigned : uns_q;
  end

  always_comb begin
    req_err = 1'b0;
    if (cur_addr < BASE_ADDR)                          req_err = 1'b1;
    if ({1'b0, cur_addr} >= LIMIT)                     req_err = 1'b1;
    if (cur_size == 2'b01 && cur_addr[0])              req_err = 1'b1;
    if (cur_size == 2'b10 && cur_addr[1:0] != 2'b00)   req_err = 1'b1;
    if (cur_size == 2'b11)                             req_err = 1'b1;
  end

  assign cur_err    = (state == IDLE) ? req_err : err_q;
  assign enter_resp = ((state == IDLE) && bus.req && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (wait_cnt == 4'd0));
  // Gated by reset so an aborted transaction can never commit its store.
  assign mem_we     = reset && enter_resp && cur_we && !cur_err;

  assign off      = cur_addr - BASE_ADDR;
  assign idx      = IDX_W'(off >> 2);
  assign old_word = mem[idx];

  always_comb begin
    lane_byte = old_word[{cur_addr[1:0], 3'b000} +: 8];
    lane_half = old_word[{cur_addr[1], 4'b0000} +: 16];
    merged    = old_word;
    case (cur_size)
      2'b00:   merged[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
      2'b01:   merged[{cur_addr[1], 4'b0000} +: 16] = cur_wdata[15:0];
      default: merged = cur_wdata;
    endcase
  end

  always_comb begin
    load_val = 32'd0;
    if (!cur_we && !cur_err) begin
      case (cur_size)
        2'b00:   load_val = cur_uns ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
        2'b01:   load_val = cur_uns ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
        default: load_val = old_word;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= merged;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= 32'd0;
      bus.busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            we_q     <= bus.we;
            addr_q   <= bus.addr;
            wdata_q  <= bus.wdata;
            size_q   <= bus.size;
            uns_q    <= bus.load_unsigned;
            err_q    <= req_err;
            bus.busy <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              bus.ready <= 1'b1;
              bus.err   <= req_err;
              bus.rdata <= load_val;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= RESP;
            bus.ready <= 1'b1;
            bus.err   <= err_q;
            bus.rdata <= load_val;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          bus.ready <= 1'b0;
          bus.err   <= 1'b0;
          bus.rdata <= 32'd0;
          bus.busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b0;
          bus.err   <= 1'b0;
          bus.rdata <= 32'd0;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder (one- and zero-wait instances)
module tb_dmem_responder;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_2000)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_2000)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, input logic u,
                        output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.size = s; bus.load_unsigned = u;
    @(posedge clk);
    #1 bus.req = 1'b0;
    lat = -1; rd = 32'd0; e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        lat = i; rd = bus.rdata; e = bus.err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0; bus.size = 0; bus.load_unsigned = 0;
    bus0.req = 0; bus0.we = 0; bus0.addr = 32'h2000; bus0.wdata = 0; bus0.size = 2'b10;
    bus0.load_unsigned = 0;
    repeat (3) @(negedge clk);
    n_assert++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
    n_assert++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_assert++; if (bus.rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    reset = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic e; int lat;
    access(1'b1, 32'h2004, 32'hDEADBEEF, 2'b10, 1'b0, rd, e, lat);
    n_assert++; if (lat != 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", lat); end
    n_assert++; if (e !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL sw_resp: got err=%b rdata=%h want err=0 rdata=0", e, rd); end
    access(1'b0, 32'h2004, 32'h0, 2'b10, 1'b0, rd, e, lat);
    n_assert++; if (lat != 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", lat); end
    n_assert++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", rd); end
    n_assert++; if (e !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b want 0", e); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic e; int lat;
    access(1'b1, 32'h2005, 32'hFFFF_FF80, 2'b00, 1'b0, rd, e, lat);
    n_assert++; if (e !== 1'b0) begin n_fail++; $display("FAIL sb_err: got %b want 0", e); end
    access(1'b0, 32'h2005, 32'h0, 2'b00, 1'b0, rd, e, lat);
    n_assert++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_signed: got %h want ffffff80", rd); end
    access(1'b0, 32'h2005, 32'h0, 2'b00, 1'b1, rd, e, lat);
    n_assert++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu: got %h want 00000080", rd); end
    access(1'b0, 32'h2004, 32'h0, 2'b10, 1'b0, rd, e, lat);
    n_assert++; if (rd !== 32'hDEAD80EF) begin n_fail++; $display("FAIL lw_after_sb: got %h want dead80ef", rd); end
    access(1'b0, 32'h2004, 32'h0, 2'b01, 1'b0, rd, e, lat);
    n_assert++; if (rd !== 32'hFFFF80EF) begin n_fail++; $display("FAIL lh_signed: got %h want ffff80ef", rd); end
    access(1'b0, 32'h2006, 32'h0, 2'b01, 1'b1, rd, e, lat);
    n_assert++; if (rd !== 32'h0000DEAD) begin n_fail++; $display("FAIL lhu_upper: got %h want 0000dead", rd); end
    access(1'b1, 32'h2006, 32'h0000_5A5A, 2'b01, 1'b0, rd, e, lat);
    access(1'b0, 32'h2004, 32'h0, 2'b10, 1'b0, rd, e, lat);
    n_assert++; if (rd !== 32'h5A5A80EF) begin n_fail++; $display("FAIL lw_after_sh: got %h want 5a5a80ef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    access(1'b1, 32'h2000, 32'hCAFEF00D, 2'b10, 1'b0, rd, e, lat);
    access(1'b1, 32'h2001, 32'h0000_1234, 2'b01, 1'b0, rd, e, lat);
    n_assert++; if (e !== 1'b1 || lat != 2) begin n_fail++; $display("FAIL sh_misaligned: got err=%b lat=%0d want err=1 lat=2", e, lat); end
    access(1'b0, 32'h2000, 32'h0, 2'b10, 1'b0, rd, e, lat);
    n_assert++; if (rd !== 32'hCAFEF00D || e !== 1'b0) begin n_fail++; $display("FAIL lw_unchanged: got %h err=%b want cafef00d err=0", rd, e); end
    access(1'b0, 32'h1FFC, 32'h0, 2'b10, 1'b0, rd, e, lat);
    n_assert++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL below_base: got err=%b rdata=%h want err=1 rdata=0", e, rd); end
    access(1'b0, 32'h2400, 32'h0, 2'b10, 1'b0, rd, e, lat);
    n_assert++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL above_top: got err=%b rdata=%h want err=1 rdata=0", e, rd); end
    access(1'b0, 32'h2000, 32'h0, 2'b11, 1'b0, rd, e, lat);
    n_assert++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL size_reserved: got err=%b rdata=%h want err=1 rdata=0", e, rd); end
    access(1'b0, 32'h2002, 32'h0, 2'b10, 1'b0, rd, e, lat);
    n_assert++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL lw_misaligned: got err=%b rdata=%h want err=1 rdata=0", e, rd); end
    access(1'b1, 32'h23FC, 32'h0BAD_CAFE, 2'b10, 1'b0, rd, e, lat);
    access(1'b0, 32'h23FC, 32'h0, 2'b10, 1'b0, rd, e, lat);
    n_assert++; if (e !== 1'b0 || rd !== 32'h0BADCAFE) begin n_fail++; $display("FAIL last_word: got err=%b rdata=%h want err=0 rdata=0badcafe", e, rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic e; int lat; int pulses;
    access(1'b1, 32'h2008, 32'h55AA55AA, 2'b10, 1'b0, rd, e, lat);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h2008; bus.wdata = 32'h11111111; bus.size = 2'b10;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    n_assert++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_in_wait: got busy=%b want 1", bus.busy); end
    reset = 1'b0;
    #1;
    n_assert++; if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin n_fail++; $display("FAIL abort_immediate: got busy=%b ready=%b want 0 0", bus.busy, bus.ready); end
    pulses = 0;
    repeat (2) begin @(negedge clk); if (bus.ready === 1'b1) pulses++; end
    reset = 1'b1;
    repeat (5) begin @(negedge clk); if (bus.ready === 1'b1) pulses++; end
    n_assert++; if (pulses != 0) begin n_fail++; $display("FAIL abort_no_ready: got %0d pulses want 0", pulses); end
    access(1'b0, 32'h2008, 32'h0, 2'b10, 1'b0, rd, e, lat);
    n_assert++; if (rd !== 32'h55AA55AA) begin n_fail++; $display("FAIL abort_no_commit: got %h want 55aa55aa", rd); end
  endtask

  task automatic test_back_to_back();
    int c1, c0, last1, last0, bad1, bad0;
    c1 = 0; c0 = 0; last1 = -1; last0 = -1; bad1 = 0; bad0 = 0;
    @(negedge clk);
    bus.req = 1'b1;  bus.we = 1'b0;  bus.addr = 32'h2004;  bus.size = 2'b10;
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h2000; bus0.size = 2'b10;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1 if (i == 11) begin bus.req = 1'b0; bus0.req = 1'b0; end
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        if (last1 >= 0 && i - last1 != 3) bad1++;
        last1 = i; c1++;
      end
      if (bus0.ready === 1'b1) begin
        if (last0 >= 0 && i - last0 != 2) bad0++;
        last0 = i; c0++;
      end
    end
    n_assert++; if (c1 != 4) begin n_fail++; $display("FAIL hold_wait1_count: got %0d want 4", c1); end
    n_assert++; if (bad1 != 0) begin n_fail++; $display("FAIL hold_wait1_spacing: got %0d bad gaps want 0", bad1); end
    n_assert++; if (c0 != 6) begin n_fail++; $display("FAIL hold_wait0_count: got %0d want 6", c0); end
    n_assert++; if (bad0 != 0) begin n_fail++; $display("FAIL hold_wait0_spacing: got %0d bad gaps want 0", bad0); end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store port.
- Accepts one request at a time, inserts a programmable number of wait states, and performs sub-word writes (byte-lane merge) and sub-word loads (lane select, sign/zero extend).
- Flags out-of-range, misaligned and reserved-size accesses.
- Sits between the core datapath's address/write-data/memwrite outputs and its read_data input, as the far end of that interface.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in storage.
- WAIT_CYCLES, 1: wait states per access, legal range 0..15.
- BASE_ADDR, 32'h0000_2000: byte address of word 0. Must be word-aligned.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- load_unsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- rdata  out  32  load result; valid only while ready=1.
- ready  out  1  one-cycle response pulse.
- err  out  1  error flag; valid with ready.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0): state=IDLE, wait counter=0, ready=0, err=0, rdata=0, busy=0. Storage contents are not reset.
- Reset asserted mid-transaction aborts it. An uncommitted store never commits. Outputs return to reset values immediately.
- IDLE, req=1: register addr, we, wdata, size and load_unsigned, plus the computed error bit.
  - If WAIT_CYCLES=0, next state is RESP.
  - Otherwise next state is WAIT, with the counter loaded to WAIT_CYCLES-1.
- WAIT: decrement the counter each cycle. When counter=0, next state is RESP.
- RESP: ready=1 and err=(registered error bit) for exactly one cycle, then IDLE.
- req is ignored in WAIT and RESP; no queuing. A req held continuously is accepted once per WAIT_CYCLES+2 cycles.
- Latency: ready is high in cycle N+WAIT_CYCLES+1, where N is the cycle in which req was sampled in IDLE.
- Error conditions (any one sets the error bit):
  - addr < BASE_ADDR;
  - addr >= BASE_ADDR + 4*DEPTH_WORDS;
  - size=01 with addr[0]=1;
  - size=10 with addr[1:0] != 0;
  - size=11.
- On error: no storage write; rdata=0.
- Word index = (addr - BASE_ADDR) >> 2. Lane = addr[1:0].
- Store commit: on the rising edge entering RESP, only when we=1 and error=0.
  - byte: writes lane byte = wdata[7:0];
  - half: writes lanes {addr[1],0} and {addr[1],1} = wdata[15:0], little-endian;
  - word: writes the full word.
  - Untouched lanes keep their old value (read-modify-write inside the block).
- Load data: rdata is registered and presented in RESP.
  - byte = lane byte, extended per load_unsigned;
  - half = selected halfword, extended;
  - word = full word.
- rdata=0 for stores and outside RESP.
- Simultaneous req and RESP: the request is not accepted. The requester must keep req asserted until it sees IDLE (busy=0).

Test Plan:
- WAIT_CYCLES=1, BASE_ADDR=0x2000. Store word 0xDEADBEEF @0x2004, then load word @0x2004 → each ready exactly 2 cycles after req sampled; load rdata=0xDEADBEEF, err=0.
- Store byte 0x80 @0x2005, then load byte signed @0x2005 → rdata=0xFFFFFF80. Load byte unsigned → 0x00000080. Load word @0x2004 → 0xDEAD80EF.
- Store half 0x1234 @0x2001 (misaligned) → ready with err=1. A following word load @0x2000 returns unchanged contents.
- Load word @0x1FFC, @0x2400 (DEPTH_WORDS=256), and size=11 @0x2000 → err=1, rdata=0 for each.
- Store word 0x11111111 @0x2008, with reset pulsed low during WAIT → ready never pulses, busy=0 immediately. A following load @0x2008 returns the previous value.
- Hold req=1 for 12 cycles with WAIT_CYCLES=1 → exactly 4 ready pulses, 3 cycles apart. With WAIT_CYCLES=0 → 6 pulses, 2 cycles apart.
